cpu_fpu_int_to_float: RTL and testbench

//   Multi-cycle integer-to-single-precision converter for FCVT.S.W / FCVT.S.WU.

---
 rtl/cpu_fpu_int_to_float.sv | 151 +++++++++++++++
 tb/tb_cpu_fpu_int_to_float.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cpu_fpu_int_to_float.sv
// -----------------------------------------------------------------------------
// cpu_fpu_int_to_float
//   Multi-cycle integer-to-binary32 converter serving FCVT.S.W (signed) and
//   FCVT.S.WU (unsigned). It shares the level request / ready handshake used by
//   the float-to-int unit behind the FPU dispatcher. Rounding is to nearest,
//   ties to even.
//
//   Flow: IDLE captures sign and magnitude, SPECIAL_CASES short-cuts a zero
//   operand, NORMALISE shifts left one bit per cycle until the MSB is set,
//   ROUND packs the result in one cycle, and PUT_Z presents it until the
//   requester drops i_request.
//
// Ports
//   i_clock    in   1   clock
//   i_reset    in   1   synchronous, active-high reset
//   i_request  in   1   level request, held until o_ready is seen
//   i_op1      in   32  integer operand, sampled in IDLE only
//   i_signed   in   1   1: two's complement operand, 0: unsigned operand
//   o_ready    out  1   result valid (registered)
//   o_result   out  32  binary32 result (registered, holds between operations)
// -----------------------------------------------------------------------------
module cpu_fpu_int_to_float (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic [31:0] i_op1,
  input  logic        i_signed,
  output logic        o_ready,
  output logic [31:0] o_result
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned BEXP_W = 8;

  // Unbiased exponent of an operand whose MSB is already in bit 31.
  localparam logic signed [EXP_W-1:0] EXP_START = 10'sd31;
  localparam logic [BEXP_W-1:0]       EXP_BIAS  = 8'd127;

  typedef enum logic [2:0] {
    IDLE,
    SPECIAL_CASES,
    NORMALISE,
    ROUND,
    PUT_Z
  } state_t;

  state_t                   state;
  logic                     sign;
  logic [DATA_W-1:0]        mag;
  logic signed [EXP_W-1:0]  exp;
  logic [DATA_W-1:0]        z;

  // Rounding datapath, only consumed in ROUND.
  logic                     guard_c;
  logic                     sticky_c;
  logic                     round_up_c;
  logic                     carry_c;
  logic [FRAC_W-1:0]        frac_c;
  logic signed [EXP_W-1:0]  exp_rnd_c;
  logic [BEXP_W-1:0]        exp_biased_c;
  logic                     neg_c;

  // Magnitude after normalisation is mag[31:8] (hidden bit in 31), guard in
  // bit 7 and the remaining bits fold into sticky.
  always_comb begin
    guard_c      = mag[7];
    sticky_c     = |mag[6:0];
    round_up_c   = guard_c & (sticky_c | mag[8]);
    // An all-ones mantissa that rounds up wraps to 1.000... with exponent + 1;
    // the fraction field wraps to zero on its own.
    carry_c      = round_up_c & (&mag[31:8]);
    frac_c       = mag[30:8] + FRAC_W'(round_up_c);
    exp_rnd_c    = carry_c ? (exp + 10'sd1) : exp;
    exp_biased_c = BEXP_W'(exp_rnd_c) + EXP_BIAS;
  end

  // Sign of the operand being accepted.
  always_comb begin
    neg_c = i_signed & i_op1[31];
  end

  // Conversion sequencer and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= IDLE;
      sign     <= 1'b0;
      mag      <= '0;
      exp      <= '0;
      z        <= '0;
      o_ready  <= 1'b0;
      o_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_ready <= 1'b0;
          if (i_request) begin
            sign  <= neg_c;
            // -0x80000000 wraps to 0x80000000, the correct unsigned magnitude.
            mag   <= neg_c ? (-i_op1) : i_op1;
            exp   <= EXP_START;
            state <= SPECIAL_CASES;
          end
        end

        SPECIAL_CASES: begin
          if (mag == '0) begin
            // Integer zero always converts to +0.0.
            z     <= '0;
            state <= PUT_Z;
          end else begin
            state <= NORMALISE;
          end
        end

        NORMALISE: begin
          if (mag[DATA_W-1]) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            exp <= exp - 10'sd1;
          end
        end

        ROUND: begin
          // Biased exponent peaks at 159, so no overflow or denormal path.
          z     <= {sign, exp_biased_c, frac_c};
          state <= PUT_Z;
        end

        PUT_Z: begin
          o_result <= z;
          if (i_request) begin
            o_ready <= 1'b1;
          end else begin
            // A request dropped before ready is seen aborts without a pulse.
            o_ready <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          o_ready <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fpu_int_to_float.sv
// -----------------------------------------------------------------------------
// tb_cpu_fpu_int_to_float
//   Directed bench for cpu_fpu_int_to_float. The driver issues conversions and
//   pushes the expected result and latency into a scoreboard queue; a monitor
//   running on the falling edge pops and compares whenever o_ready rises, and
//   also watches reset values, ready hold/fall behaviour and result stability.
// -----------------------------------------------------------------------------
module tb_cpu_fpu_int_to_float;

  logic        i_clock;
  logic        i_reset;
  logic        i_request;
  logic [31:0] i_op1;
  logic        i_signed;
  logic        o_ready;
  logic [31:0] o_result;

  cpu_fpu_int_to_float dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_request(i_request),
    .i_op1    (i_op1),
    .i_signed (i_signed),
    .o_ready  (o_ready),
    .o_result (o_result)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          start;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc         = 0;
  logic        rst_q       = 1'b0;
  logic        req_q       = 1'b0;
  int          total       = 0;
  int          bad         = 0;
  logic        prev_ready  = 1'b0;
  logic [31:0] last_result = 32'h0;
  int          wait_cnt    = 0;

  // Edge bookkeeping: posedge count plus the inputs the DUT saw at that edge.
  always @(posedge i_clock) begin
    cyc   <= cyc + 1;
    rst_q <= i_reset;
    req_q <= i_request;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: all comparisons live here.
  always @(negedge i_clock) begin
    exp_t e;
    if (rst_q === 1'b1) begin
      check("reset_ready", {31'b0, o_ready}, 32'h0);
      check("reset_result", o_result, 32'h0);
      last_result = 32'h0;
      wait_cnt    = 0;
    end else if (o_ready === 1'b1 && prev_ready === 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, o_result, e.res);
        check({e.name, "_latency"}, 32'(cyc - e.start), 32'(e.lat));
      end
      last_result = o_result;
      wait_cnt    = 0;
    end else begin
      if (prev_ready === 1'b1)
        check("ready_follows_request", {31'b0, o_ready}, {31'b0, req_q});
      check("result_hold", o_result, last_result);
      if (o_ready !== 1'b1 && sb.size() != 0) begin
        wait_cnt = wait_cnt + 1;
        if (wait_cnt > 80) begin
          e = sb.pop_front();
          check({e.name, "_timeout"}, 32'h0, 32'h1);
          wait_cnt = 0;
        end
      end
    end
    prev_ready = (rst_q === 1'b1) ? 1'b0 : o_ready;
  end

  // Issue one conversion starting at the current negedge; returns on the
  // negedge after the DUT has seen the request drop (DUT back in IDLE).
  task automatic convert(input string name, input logic [31:0] op, input logic sgn,
                         input logic [31:0] res, input int lat, input int hold);
    int n;
    i_request = 1'b1;
    i_op1     = op;
    i_signed  = sgn;
    sb.push_back('{res: res, lat: lat, start: cyc + 1, name: name});
    n = 0;
    do begin
      @(negedge i_clock);
      // Operand changes after sampling must not disturb the conversion.
      i_op1    = $urandom;
      i_signed = ~i_signed;
      n++;
    end while (o_ready !== 1'b1 && n < 100);
    repeat (hold) @(negedge i_clock);
    i_request = 1'b0;
    @(negedge i_clock);
  endtask

  initial begin
    int n;
    i_reset   = 1'b1;
    i_request = 1'b0;
    i_op1     = 32'h0;
    i_signed  = 1'b0;
    repeat (3) @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock);

    convert("one_s",       32'h0000_0001, 1'b1, 32'h3F80_0000, 35, 3);
    convert("minus_one_s", 32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 35, 1);
    convert("intmin_s",    32'h8000_0000, 1'b1, 32'hCF00_0000,  4, 0);
    convert("intmin_u",    32'h8000_0000, 1'b0, 32'h4F00_0000,  4, 1);
    convert("zero_s",      32'h0000_0000, 1'b1, 32'h0000_0000,  2, 1);
    convert("tie_even",    32'h0100_0001, 1'b0, 32'h4B80_0000, 11, 0);
    convert("tie_up",      32'h0100_0003, 1'b1, 32'h4B80_0002, 11, 1);
    convert("all_ones_u",  32'hFFFF_FFFF, 1'b0, 32'h4F80_0000,  4, 1);
    convert("minus_7_s",   32'hFFFF_FFF9, 1'b1, 32'hC0E0_0000, 33, 0);

    // Reset in the middle of normalising 1; no result is expected from it.
    i_request = 1'b1;
    i_op1     = 32'h0000_0001;
    i_signed  = 1'b1;
    repeat (10) @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset   = 1'b0;
    i_request = 1'b0;
    @(negedge i_clock);

    convert("two_after_reset", 32'h0000_0002, 1'b0, 32'h4000_0000, 34, 1);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge i_clock);
      n++;
    end
    repeat (3) @(negedge i_clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
